// File: rtl/dsp_acc_pkg.sv
// Shared types and lane geometry for the accumulate stage behind the combined multiplier.
package dsp_acc_pkg;

    localparam int PROD_W = 74;

    localparam logic [1:0] MODE_18X19 = 2'b00;
    localparam logic [1:0] MODE_27X27 = 2'b01;
    localparam logic [1:0] MODE_9X9   = 2'b10;  // bit 0 is don't-care

    localparam int LANES_18X19 = 2;
    localparam int W_18X19     = 37;
    localparam int LANES_27X27 = 1;
    localparam int W_27X27     = 74;
    localparam int LANES_9X9   = 4;
    localparam int W_9X9       = 18;

    typedef struct packed {
        logic [1:0]        mode;
        logic [PROD_W-1:0] prod;
        logic              accum;
        logic              last;
    } beat_t;

    // Bit i set means no carry propagates into bit i (lane LSB positions).
    // In 9x9 mode bit 72 starts the unused two-bit tail.
    function automatic logic [PROD_W-1:0] carry_kill_mask(input logic [1:0] mode);
        logic [PROD_W-1:0] m;
        m = '0;
        if (mode[1]) begin
            for (int l = 0; l <= LANES_9X9; l++) m[l*W_9X9] = 1'b1;
        end else if (mode[0]) begin
            for (int l = 0; l < LANES_27X27; l++) m[l*W_27X27] = 1'b1;
        end else begin
            for (int l = 0; l < LANES_18X19; l++) m[l*W_18X19] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/dsp_lane_adder.sv
// Segmented 74-bit adder: carries stop at lane boundaries, optional per-lane saturation.
module dsp_lane_adder
    import dsp_acc_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    input  logic [1:0]        mode,
    input  logic              sat_en,
    output logic [PROD_W-1:0] sum,
    output logic [3:0]        carry
);

    logic [PROD_W-1:0]      kill;
    logic [PROD_W:0]        kill_ext;
    logic [PROD_W-1:0]      raw;
    logic [PROD_W-1:0][2:0] lane_of;
    logic [2:0]             ln;
    logic                   c;

    always_comb begin
        kill     = carry_kill_mask(mode);
        kill_ext = {1'b1, kill};
        raw      = '0;
        lane_of  = '0;
        carry    = '0;
        sum      = '0;
        ln       = 3'd0;
        c        = 1'b0;
        for (int i = 0; i < PROD_W; i++) begin
            if (kill[i]) begin
                c = 1'b0;
                if (i != 0) ln = ln + 3'd1;
            end
            raw[i]     = a[i] ^ b[i] ^ c;
            c          = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            lane_of[i] = ln;
            // Lane index 4 is the dead tail in 9x9 mode; its carry is meaningless.
            if (kill_ext[i+1] && ln < 3'd4) carry[ln[1:0]] = c;
        end
        for (int i = 0; i < PROD_W; i++) begin
            if (lane_of[i] == 3'd4)                   sum[i] = 1'b0;
            else if (sat_en && carry[lane_of[i][1:0]]) sum[i] = 1'b1;
            else                                       sum[i] = raw[i];
        end
    end

endmodule

// File: rtl/dsp_accumulator.sv
// Two-register accumulate stage: S0 captures the beat, S1 folds it into the group sum
// and loads the output register when the beat closes the group.
module dsp_accumulator
    import dsp_acc_pkg::*;
#(
    parameter bit SAT_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_accum,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_mode,
    output logic [PROD_W-1:0] out_result,
    output logic [3:0]        out_ovf,
    output logic              out_mode_err
);

    beat_t             s0_q, s0_d;
    logic              s0_valid_q, s0_valid_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [1:0]        acc_mode_q, acc_mode_d;
    logic [3:0]        ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              open_q, open_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_mode_q, out_mode_d;
    logic [PROD_W-1:0] out_result_q, out_result_d;
    logic [3:0]        out_ovf_q, out_ovf_d;
    logic              out_err_q, out_err_d;

    logic              stall, start, mismatch;
    logic [PROD_W-1:0] add_a, sum;
    logic [3:0]        lane_carry;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    // A fresh group starts from zero, so the adder's output is just the product.
    assign mismatch = open_q & s0_q.accum & (s0_q.mode != acc_mode_q);
    assign start    = ~open_q | ~s0_q.accum | mismatch;
    assign add_a    = start ? '0 : acc_q;

    dsp_lane_adder u_add (
        .a      (add_a),
        .b      (s0_q.prod),
        .mode   (s0_q.mode),
        .sat_en (SAT_EN),
        .sum    (sum),
        .carry  (lane_carry)
    );

    always_comb begin
        s0_d         = s0_q;
        s0_valid_d   = s0_valid_q;
        acc_d        = acc_q;
        acc_mode_d   = acc_mode_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        open_d       = open_q;
        out_valid_d  = out_valid_q;
        out_mode_d   = out_mode_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_err_d    = out_err_q;
        if (!stall) begin
            s0_valid_d = in_valid;
            if (in_valid) s0_d = '{mode: in_mode, prod: in_prod, accum: in_accum, last: in_last};
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            if (s0_valid_q) begin
                acc_d      = sum;
                acc_mode_d = s0_q.mode;
                ovf_d      = (start ? 4'b0 : ovf_q) | lane_carry;
                err_d      = start ? mismatch : err_q;
                open_d     = ~s0_q.last;
                if (s0_q.last) begin
                    out_valid_d  = 1'b1;
                    out_mode_d   = s0_q.mode;
                    out_result_d = sum;
                    out_ovf_d    = ovf_d;
                    out_err_d    = err_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q         <= '0;
            s0_valid_q   <= 1'b0;
            acc_q        <= '0;
            acc_mode_q   <= 2'b00;
            ovf_q        <= '0;
            err_q        <= 1'b0;
            open_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_mode_q   <= 2'b00;
            out_result_q <= '0;
            out_ovf_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            s0_q         <= s0_d;
            s0_valid_q   <= s0_valid_d;
            acc_q        <= acc_d;
            acc_mode_q   <= acc_mode_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            open_q       <= open_d;
            out_valid_q  <= out_valid_d;
            out_mode_q   <= out_mode_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_mode     = out_mode_q;
    assign out_result   = out_result_q;
    assign out_ovf      = out_ovf_q;
    assign out_mode_err = out_err_q;

endmodule

// File: tb/tb_dsp_accumulator.sv
// Bench for dsp_accumulator: wrap and saturate instances side by side against a lane-arithmetic model.
module tb_dsp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_accum, in_last, out_ready;
    logic [1:0]  in_mode;
    logic [73:0] in_prod;

    logic        in_ready0, out_valid0, out_err0, in_ready1, out_valid1, out_err1;
    logic [1:0]  out_mode0, out_mode1;
    logic [73:0] out_result0, out_result1;
    logic [3:0]  out_ovf0, out_ovf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_accumulator #(.SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_mode(in_mode),
        .in_prod(in_prod), .in_accum(in_accum), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_mode(out_mode0), .out_result(out_result0),
        .out_ovf(out_ovf0), .out_mode_err(out_err0));

    dsp_accumulator #(.SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_mode(in_mode),
        .in_prod(in_prod), .in_accum(in_accum), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_mode(out_mode1), .out_result(out_result1),
        .out_ovf(out_ovf1), .out_mode_err(out_err1));

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [73:0] res;
        logic [1:0]  mode;
        logic [3:0]  ovf;
        logic        err;
    } exp_t;

    exp_t        q0[$], q1[$];
    bit          m_open;
    logic [1:0]  m_mode;
    logic [73:0] m_acc [2];
    logic [3:0]  m_ovf [2];
    bit          m_err;

    function automatic int lane_w(input logic [1:0] m);
        return m[1] ? 18 : (m[0] ? 74 : 37);
    endfunction

    function automatic int lane_n(input logic [1:0] m);
        return m[1] ? 4 : (m[0] ? 1 : 2);
    endfunction

    task automatic model_beat(input logic [1:0] mode, input logic [73:0] prod, input bit accum, input bit last);
        bit          start;
        int          w, n;
        logic [74:0] lmask, pa, aa, t;
        logic [73:0] nacc;
        logic [3:0]  novf;
        exp_t        e;
        start = !m_open || !accum || (mode != m_mode);
        w     = lane_w(mode);
        n     = lane_n(mode);
        lmask = (75'd1 << w) - 75'd1;
        for (int s = 0; s < 2; s++) begin
            nacc = '0;
            novf = start ? 4'b0 : m_ovf[s];
            for (int l = 0; l < n; l++) begin
                pa = ({1'b0, prod} >> (l * w)) & lmask;
                aa = start ? 75'd0 : (({1'b0, m_acc[s]} >> (l * w)) & lmask);
                t  = aa + pa;
                if (t > lmask) begin
                    novf[l] = 1'b1;
                    t = (s == 1) ? lmask : (t & lmask);
                end
                nacc = nacc | 74'(t << (l * w));
            end
            m_acc[s] = nacc;
            m_ovf[s] = novf;
        end
        if (start) m_err = m_open && accum && (mode != m_mode);
        m_mode = mode;
        m_open = !last;
        if (last) begin
            e = '{res: m_acc[0], mode: mode, ovf: m_ovf[0], err: m_err};
            q0.push_back(e);
            e = '{res: m_acc[1], mode: mode, ovf: m_ovf[1], err: m_err};
            q1.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            m_open = 1'b0;
            m_err  = 1'b0;
            m_mode = 2'b00;
        end else begin
            if (out_valid0 && out_ready && q0.size() > 0) void'(q0.pop_front());
            if (out_valid1 && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (in_valid && in_ready0) model_beat(in_mode, in_prod, in_accum, in_last);
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            chk("in_ready", {73'd0, in_ready0}, {73'd0, !(out_valid0 && !out_ready)});
            chk("valid_pair", {73'd0, out_valid1}, {73'd0, out_valid0});
            if (out_valid0) begin
                if (q0.size() == 0) chk("spurious_out_wrap", 74'd1, 74'd0);
                else begin
                    chk("res_wrap", out_result0, q0[0].res);
                    chk("mode_wrap", {72'd0, out_mode0}, {72'd0, q0[0].mode});
                    chk("ovf_wrap", {70'd0, out_ovf0}, {70'd0, q0[0].ovf});
                    chk("err_wrap", {73'd0, out_err0}, {73'd0, q0[0].err});
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("spurious_out_sat", 74'd1, 74'd0);
                else begin
                    chk("res_sat", out_result1, q1[0].res);
                    chk("mode_sat", {72'd0, out_mode1}, {72'd0, q1[0].mode});
                    chk("ovf_sat", {70'd0, out_ovf1}, {70'd0, q1[0].ovf});
                    chk("err_sat", {73'd0, out_err1}, {73'd0, q1[0].err});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] mode, input logic [73:0] prod, input bit accum, input bit last);
        int n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 74'd0, 74'd1);
        in_valid = 1'b1; in_mode = mode; in_prod = prod; in_accum = accum; in_last = last;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid0 && n < 20);
        if (!out_valid0) chk("out_timeout", 74'd0, 74'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {73'd0, out_valid0 | out_valid1}, 74'd0);
        chk({tag, "_result"}, out_result0 | out_result1, 74'd0);
        chk({tag, "_mode"}, {72'd0, out_mode0 | out_mode1}, 74'd0);
        chk({tag, "_ovf"}, {70'd0, out_ovf0 | out_ovf1}, 74'd0);
        chk({tag, "_err"}, {73'd0, out_err0 | out_err1}, 74'd0);
        chk({tag, "_in_ready"}, {73'd0, in_ready0 & in_ready1}, 74'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          cnt;
        bit          took;
        logic [1:0]  pmode;
        logic [95:0] r;
        rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_prod = '0;
        in_accum = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // single-beat group, exact two-edge latency
        drive(2'b00, {37'd5, 37'd7}, 1'b0, 1'b1);
        #1 chk("lat_early", {73'd0, out_valid0}, 74'd0);
        idle();
        @(posedge clk); #1;
        chk("m00_valid", {73'd0, out_valid0}, 74'd1);
        chk("m00_result", out_result0, {37'd5, 37'd7});
        chk("m00_ovf", {70'd0, out_ovf0}, 74'd0);
        chk("m00_mode", {72'd0, out_mode0}, 74'd0);

        // 9x9 lane carry stops at lane boundary; saturating instance pins lane0
        drive(2'b10, {36'd0, 18'h00001, 18'h3FFFF}, 1'b0, 1'b0);
        drive(2'b10, 74'h1, 1'b1, 1'b1);
        idle();
        wait_out();
        chk("m9_wrap_res", out_result0, 74'h40000);
        chk("m9_wrap_ovf", {70'd0, out_ovf0}, 74'd1);
        chk("m9_sat_res", out_result1, 74'h7FFFF);
        chk("m9_sat_ovf", {70'd0, out_ovf1}, 74'd1);

        // 74-bit lane, three back-to-back beats, one result
        drive(2'b01, 74'd1000, 1'b0, 1'b0);
        drive(2'b01, 74'd1000, 1'b1, 1'b0);
        drive(2'b01, 74'd1000, 1'b1, 1'b1);
        idle();
        wait_out();
        chk("m01_result", out_result0, 74'd3000);
        chk("m01_ovf", {70'd0, out_ovf0}, 74'd0);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid0) cnt++;
        end
        chk("m01_single_valid", 74'(cnt), 74'd0);

        // mode mismatch turns accumulate into load
        drive(2'b00, 74'd9, 1'b0, 1'b0);
        drive(2'b01, 74'd4, 1'b1, 1'b1);
        idle();
        wait_out();
        chk("mm_result", out_result0, 74'd4);
        chk("mm_mode", {72'd0, out_mode0}, 74'd1);
        chk("mm_err", {73'd0, out_err0}, 74'd1);

        // backpressure: A held, B queued in S0, C held by the source
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        drive(2'b00, 74'd11, 1'b0, 1'b1);
        drive(2'b00, 74'd22, 1'b0, 1'b1);
        @(negedge clk);
        in_mode = 2'b00; in_prod = 74'd33; in_accum = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {73'd0, in_ready0}, 74'd0);
            chk("bp_hold", out_result0, 74'd11);
            chk("bp_valid", {73'd0, out_valid0}, 74'd1);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_b", out_result0, 74'd22);
        chk("bp_next_b_valid", {73'd0, out_valid0}, 74'd1);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_next_c", out_result0, 74'd33);

        // reset mid-group discards everything in flight
        repeat (3) @(negedge clk);
        drive(2'b00, 74'd1, 1'b0, 1'b0);
        drive(2'b00, 74'd2, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 chk_zero_outputs("mid_rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 chk_zero_outputs("post_rst");
        drive(2'b00, 74'd3, 1'b1, 1'b1);
        idle();
        wait_out();
        chk("rst_result", out_result0, 74'd3);
        chk("rst_err", {73'd0, out_err0}, 74'd0);

        // randomized traffic with random backpressure
        took  = 1'b1;
        pmode = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                if ($urandom_range(0, 4) == 0) pmode = 2'($urandom_range(0, 2));
                r        = {$urandom(), $urandom(), $urandom()};
                in_valid = ($urandom_range(0, 3) != 0);
                in_mode  = pmode;
                in_prod  = r[73:0];
                in_accum = ($urandom_range(0, 3) != 0);
                in_last  = ($urandom_range(0, 2) == 0);
            end
            @(posedge clk);
            took = in_valid && in_ready0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_wrap", 74'(q0.size()), 74'd0);
        chk("drain_sat", 74'(q1.size()), 74'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
